// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with private HI/LO.
// An accepted operation spends 32 cycles in CALC and one cycle in FIX, which
// writes HI/LO. MTHI/MTLO write HI/LO directly while the unit is idle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request an operation (sampled only while busy = 0)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a  rs: multiplicand / dividend
//   operand_b  rt: multiplier / divisor
//   hi_we      MTHI strobe (idle only)
//   lo_we      MTLO strobe (idle only)
//   mt_data    MTHI/MTLO data
//   busy       operation in flight (registered)
//   done       one-cycle pulse after HI/LO are written by an operation
//   hi, lo     HI/LO register outputs
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    // acc[31:0]: multiplier / dividend shifting out, quotient shifting in.
    // acc[63:32]: partial product high half / partial remainder.
    logic [ACC_W-1:0]  acc_q, acc_d;
    // Multiplicand or divisor magnitude.
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              signed_op_c;
    logic [XLEN-1:0]   abs_a_c;
    logic [XLEN-1:0]   abs_b_c;
    logic [XLEN:0]     mul_sum_c;
    logic [XLEN:0]     div_shift_c;
    logic [XLEN+1:0]   div_diff_c;
    logic [XLEN-1:0]   quot_c;
    logic [XLEN-1:0]   rem_c;
    logic              neg_res_c;

    // Operand magnitudes; 0x80000000 maps to itself and is read as unsigned.
    assign signed_op_c = ~op[0];
    assign abs_a_c     = (signed_op_c && operand_a[XLEN-1]) ? (XLEN'(0) - operand_a) : operand_a;
    assign abs_b_c     = (signed_op_c && operand_b[XLEN-1]) ? (XLEN'(0) - operand_b) : operand_b;

    // Shift-add step: conditionally add multiplicand into the high half.
    assign mul_sum_c   = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : XLEN'(0))};

    // Restoring step: 33-bit shifted remainder minus divisor; bit 33 is the borrow.
    assign div_shift_c = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    assign div_diff_c  = {1'b0, div_shift_c} - {2'b00, opb_q};

    assign quot_c      = acc_q[XLEN-1:0];
    assign rem_c       = acc_q[ACC_W-1:XLEN];
    assign neg_res_c   = ~op_q[0] & (sign_a_q ^ sign_b_q);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = mt_data;
                if (lo_we) lo_d = mt_data;
                if (start) begin
                    state_d  = S_CALC;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    op_d     = op;
                    sign_a_d = signed_op_c & operand_a[XLEN-1];
                    sign_b_d = signed_op_c & operand_b[XLEN-1];
                    acc_d    = {XLEN'(0), abs_a_c};
                    opb_d    = abs_b_c;
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[1]) begin
                    if (!div_diff_c[XLEN+1]) begin
                        acc_d = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
            end

            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                if (op_q[1]) begin
                    if (opb_q == XLEN'(0)) begin
                        // A zero divisor never borrows: quotient is all ones and the
                        // remainder is |a|; restoring the sign yields the raw dividend.
                        lo_d = quot_c;
                        hi_d = sign_a_q ? (XLEN'(0) - rem_c) : rem_c;
                    end else begin
                        lo_d = neg_res_c ? (XLEN'(0) - quot_c) : quot_c;
                        hi_d = (~op_q[0] & sign_a_q) ? (XLEN'(0) - rem_c) : rem_c;
                    end
                end else begin
                    {hi_d, lo_d} = neg_res_c ? (ACC_W'(0) - acc_q) : acc_q;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, busy/MT/reset
// sequences, and randomized back-to-back operations against an arithmetic model.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .mt_data   (mt_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics in plain 64-bit arithmetic. Returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue an operation at the current negedge and follow it to the cycle after
    // FIX. Optional: an interfering start/MT at busy cycle 'inject', and an MT
    // write on the accepting edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int inject,
                         input logic hwe, input logic lwe, input logic [31:0] md,
                         input string tag);
        int n;
        logic stable;
        logic early_done;
        logic [31:0] prev_hi, prev_lo;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        hi_we = hwe; lo_we = lwe; mt_data = md;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        if (hwe) check32({tag, " mthi_with_start"}, hi, md);
        if (lwe) check32({tag, " mtlo_with_start"}, lo, md);
        prev_hi = hi;
        prev_lo = lo;
        stable = 1'b1;
        early_done = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (done !== 1'b0) early_done = 1'b1;
            if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
            if (n == inject) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
                operand_a = $urandom; operand_b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check32({tag, " busy_cycles"}, 32'(n), 32'd33);
        check32({tag, " no_early_done"}, {31'h0, early_done}, 32'd0);
        check32({tag, " hilo_stable"}, {31'h0, stable}, 32'd1);
        check32({tag, " done_pulse"}, {31'h0, done}, 32'd1);
        check32({tag, " hi"}, hi, eh);
        check32({tag, " lo"}, lo, el);
    endtask

    initial begin
        logic [63:0] m;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[10] = '{OP_MULTU, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; mt_data = '0;
        repeat (2) @(negedge clk);
        check32("reset busy", {31'h0, busy}, 32'd0);
        check32("reset done", {31'h0, done}, 32'd0);
        check32("reset hi", hi, 32'h0);
        check32("reset lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // MTLO then MTHI in idle.
        lo_we = 1'b1; mt_data = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        check32("mtlo lo", lo, 32'h0000_1234);
        hi_we = 1'b1; mt_data = 32'h0000_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check32("mthi hi", hi, 32'h0000_5678);
        check32("mthi lo_kept", lo, 32'h0000_1234);

        // Directed table, issued back to back.
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                  0, 1'b0, 1'b0, 32'h0, $sformatf("vec%0d", i));
        end

        // Start and MT strobes at busy cycle 10 must be ignored.
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
              10, 1'b0, 1'b0, 32'h0, "busy_protect");

        // MT write on the accepting edge lands, then FIX overwrites both.
        do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14,
              0, 1'b1, 1'b1, 32'hCAFE_F00D, "start_with_mt");

        // Randomized back-to-back operations against the model.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = 32'h0;
            if (i % 7 == 3) ra = 32'h8000_0000;
            if (i % 5 == 2) rb = 32'($urandom_range(1, 20));
            if (i % 8 == 5) rb = 32'hFFFF_FFFF;
            m = model(ro, ra, rb);
            do_op(ro, ra, rb, m[63:32], m[31:0], 0, 1'b0, 1'b0, 32'h0,
                  $sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb));
        end

        // Reset between edges in the middle of a DIV.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'hA5A5_A5A5;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check32("pre_reset busy", {31'h0, busy}, 32'd1);
        check32("pre_reset lo", lo, 32'hA5A5_A5A5);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check32("midop_reset busy", {31'h0, busy}, 32'd0);
        check32("midop_reset done", {31'h0, done}, 32'd0);
        check32("midop_reset hi", hi, 32'h0);
        check32("midop_reset lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1'b0, 1'b0, 32'h0, "after_reset");
        @(negedge clk);
        check32("done_clears", {31'h0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the execute stage of the pipelined MIPS CPU. It consumes the two operands read from the register file (rs, rt) for MULT/MULTU/DIV/DIVU, computes over 33 cycles, and holds the result in private HI/LO registers. MFHI/MFLO read HI/LO and return them to the register file through write-back. The hazard unit stalls the pipeline on `busy`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation. Sampled only while `busy`=0.
- `op` input 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a` input 32: rs value, the multiplicand or dividend.
- `operand_b` input 32: rt value, the multiplier or divisor.
- `hi_we` input 1: MTHI write strobe.
- `lo_we` input 1: MTLO write strobe.
- `mt_data` input 32: data for MTHI/MTLO.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when HI/LO have just been updated by an operation.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States:
  - IDLE, then CALC after 32 iterations, then FIX, then back to IDLE.
  - A 6-bit iteration counter is active in CALC.
- Entry to CALC:
  - Happens at a rising edge where `start`=1 and state=IDLE.
  - Latch `op`.
  - Signed ops (MULT, DIV): latch |operand_a| and |operand_b|, plus sign(a) and sign(b).
  - Unsigned ops: latch raw operands.
  - |0x80000000| is 0x80000000, treated as unsigned.
- CALC iterations, one per cycle, 32 in total:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle, 32-bit remainder.
- FIX (one cycle) writes the result:
  - Multiply: {HI,LO} = product. For MULT, the 64-bit product is negated when sign(a)≠sign(b).
  - Divide: LO = quotient, HI = remainder. For DIV, the quotient is negated when signs differ; the remainder takes the sign of the dividend.
  - Returns to IDLE.
- Divide by zero (DIV or DIVU with operand_b=0):
  - Still takes the full 33 cycles.
  - LO=0xFFFFFFFF, HI=operand_a as the raw value.
  - No sign fix is applied.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` write `mt_data` to HI/LO at the edge.
  - While `busy`=1 they are ignored; the hazard unit guarantees they do not occur then.
- `start` while `busy`=1 is ignored. The operation in flight continues unaffected.
- `start` together with `hi_we`/`lo_we` in IDLE: the MT write takes effect, then the operation's FIX overwrites both HI and LO.
- `op` and operands are don't-care except on the accepting edge.

## Timing
- Reset (asynchronous, any time including mid-operation):
  - State=IDLE, counter=0.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Any operation in progress is discarded.
- Let edge E0 be the edge that accepts `start`.
  - `busy`=1 from after E0 through the cycle before E33.
  - Edges E1..E32 are the CALC iterations.
  - E33 is FIX: HI/LO are written, `busy` goes to 0, and `done` goes to 1 for exactly the cycle after E33.
- `hi`/`lo` are direct register outputs. They are stable throughout `busy`=1 and hold the previous values until E33.
- Back-to-back: `start` may be asserted in the cycle following E33, i.e. the earliest next accept is E34.
- `busy` is a registered output, with no combinational path from `start`. The hazard unit must therefore stall the MFHI/MFLO issued right after MULT/DIV using its own decode of that MULT/DIV.

## Test plan
- MULT: a=0xFFFFFFFD (-3), b=5. Expect HI=0xFFFFFFFF, LO=0xFFFFFFF1 at E33. `busy` high for exactly 33 cycles; `done` pulses once.
- MULTU: a=b=0xFFFFFFFF. Expect HI=0xFFFFFFFE, LO=0x00000001. With MULT on the same operands, expect HI=0, LO=1.
- DIV: a=0xFFFFFFF9 (-7), b=2. Expect LO=0xFFFFFFFD, HI=0xFFFFFFFF. With DIVU 100/7, expect LO=14, HI=2.
- Divide edge cases:
  - DIVU 100/0: LO=0xFFFFFFFF, HI=0x64.
  - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Busy protection:
  - Assert `start` with different operands and `hi_we`=1 at cycle 10 of an operation. Both are ignored; the result matches the first operation.
  - MTLO of 0x1234 in IDLE gives `lo`=0x1234 next cycle.
- Reset mid-operation: assert `reset` at cycle 15 of a DIV, asynchronously between edges. `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a new MULTU 3×4 gives LO=12, HI=0.
